// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    // Receive FSM states, one per frame phase after the start bit.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // Start, parity and stop bits surround the payload.
    localparam int         PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                           input logic                     par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchroniser followed by a run-length debounce. The filtered
// level only moves after FILTER_LEN consecutive samples disagree with it;
// fall_o is a one-cycle strobe in the first cycle the filtered level is low.
module ps2_input_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          flip;

    // A sample that agrees with the current level restarts the run.
    always_comb begin
        flip  = 1'b0;
        cnt_d = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                flip = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, run counter and filtered level; the pin idles high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            fall_q  <= flip & level_q;
            if (flip) begin
                level_q <= ~level_q;
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard frame receiver: filters the pins, assembles 11-bit frames,
// reports raw scan codes and folds E0/F0 prefixes into key events.
//
// state  | meaning
// IDLE   | waiting for a start bit (data low on a kclk fall)
// DATA   | shifting in eight payload bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking parity and stop bit, then reporting the frame
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 30000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic [7:0] scan_code_o,
    output logic       scan_valid_o,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_release_o,
    output logic       key_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    // Matching one below the last count lets the abort land exactly
    // TIMEOUT_CYC cycles after the fall strobe, with the pulse registered.
    localparam logic [TW-1:0] TO_HIT = TW'(TIMEOUT_CYC - 2);
    localparam logic [2:0] BIT_LAST = 3'(PS2_DATA_BITS - 1);

    logic kclk_lvl;
    logic kclk_fall;
    logic fall;

    logic kdata_s1_q;
    logic kdata_s2_q;

    ps2_state_t              state_q;
    logic [2:0]              bit_cnt_q;
    logic [PS2_DATA_BITS-1:0] shreg_q;
    logic                    par_q;
    logic [TW-1:0]           to_cnt_q;
    logic [TW-1:0]           to_cnt_d;
    logic                    timeout;

    logic [7:0] scan_code_q;
    logic       scan_valid_q;
    logic       parity_err_q;
    logic       frame_err_q;

    logic       ext_flag_q;
    logic       brk_flag_q;
    logic [7:0] key_code_q;
    logic       key_ext_q;
    logic       key_rel_q;
    logic       key_valid_q;

    ps2_input_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_kclk_filter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .in_i    (kclk_i),
        .level_o (kclk_lvl),
        .fall_o  (kclk_fall)
    );

    // The strobe coincides with the low level; requiring both keeps a
    // stray strobe from ever being taken while the clock reads high.
    assign fall = kclk_fall & ~kclk_lvl;

    // Data needs no debounce: it is only looked at on a filtered fall,
    // long after it has settled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kdata_s1_q <= 1'b1;
            kdata_s2_q <= 1'b1;
        end else begin
            kdata_s1_q <= kdata_i;
            kdata_s2_q <= kdata_s1_q;
        end
    end

    // Inter-edge watchdog: restarts on every fall and while idle.
    always_comb begin
        timeout  = (state_q != IDLE) && (to_cnt_q == TO_HIT);
        to_cnt_d = to_cnt_q + 1'b1;
        if (state_q == IDLE || fall || timeout) begin
            to_cnt_d = '0;
        end
    end

    // Receive FSM with registered frame-result pulses; a timeout beats a
    // simultaneous fall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            scan_code_q  <= '0;
            scan_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            scan_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            to_cnt_q     <= to_cnt_d;
            if (timeout) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                unique case (state_q)
                    IDLE: begin
                        if (!kdata_s2_q) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shreg_q   <= {kdata_s2_q, shreg_q[PS2_DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= kdata_s2_q;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!ps2_parity_ok(shreg_q, par_q)) begin
                            parity_err_q <= 1'b1;
                        end else if (!kdata_s2_q) begin
                            frame_err_q <= 1'b1;
                        end else begin
                            scan_code_q  <= shreg_q;
                            scan_valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Prefix decoder: remembers E0/F0 until a plain code completes the
    // sequence; any dropped frame abandons a half-built sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ext_flag_q  <= 1'b0;
            brk_flag_q  <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_rel_q   <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (parity_err_q || frame_err_q) begin
                ext_flag_q <= 1'b0;
                brk_flag_q <= 1'b0;
            end else if (scan_valid_q) begin
                if (scan_code_q == PS2_PREFIX_EXT) begin
                    ext_flag_q <= 1'b1;
                end else if (scan_code_q == PS2_PREFIX_BRK) begin
                    brk_flag_q <= 1'b1;
                end else begin
                    key_code_q  <= scan_code_q;
                    key_ext_q   <= ext_flag_q;
                    key_rel_q   <= brk_flag_q;
                    key_valid_q <= 1'b1;
                    ext_flag_q  <= 1'b0;
                    brk_flag_q  <= 1'b0;
                end
            end
        end
    end

    assign scan_code_o   = scan_code_q;
    assign scan_valid_o  = scan_valid_q;
    assign parity_err_o  = parity_err_q;
    assign frame_err_o   = frame_err_q;
    assign key_code_o    = key_code_q;
    assign key_ext_o     = key_ext_q;
    assign key_release_o = key_rel_q;
    assign key_valid_o   = key_valid_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: a keyboard-side driver produces frames, an
// event-level model predicts the pulses and held outputs, and a monitor
// compares the DUT against it every cycle.
module tb_ps2_rx_frame;

    localparam int FL = 8;
    localparam int TO = 300;

    localparam int K_SCAN = 0;
    localparam int K_KEY  = 1;
    localparam int K_PERR = 2;
    localparam int K_FERR = 3;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       tmo;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       kclk_i = 1'b1;
    logic       kdata_i = 1'b1;
    logic [7:0] scan_code_o;
    logic       scan_valid_o;
    logic [7:0] key_code_o;
    logic       key_ext_o;
    logic       key_release_o;
    logic       key_valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       busy_o;

    ps2_rx_frame #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .kclk_i        (kclk_i),
        .kdata_i       (kdata_i),
        .scan_code_o   (scan_code_o),
        .scan_valid_o  (scan_valid_o),
        .key_code_o    (key_code_o),
        .key_ext_o     (key_ext_o),
        .key_release_o (key_release_o),
        .key_valid_o   (key_valid_o),
        .parity_err_o  (parity_err_o),
        .frame_err_o   (frame_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    ev_t exp_q[$];
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    int last_fall_drv = 0;
    int last_scan_cyc = 0;
    int n_scan = 0, n_key = 0, n_perr = 0, n_ferr = 0;

    logic [7:0] m_scan = 8'h00;
    logic [7:0] m_key  = 8'h00;
    logic       m_kext = 1'b0;
    logic       m_krel = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic ev_t mk(input int kind, input logic [7:0] code,
                               input logic ext, input logic rel, input logic tmo);
        ev_t e;
        e.kind = kind; e.code = code; e.ext = ext; e.rel = rel; e.tmo = tmo;
        return e;
    endfunction

    // Event-level prediction of one complete frame.
    task automatic expect_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        if (bad_par) begin
            exp_q.push_back(mk(K_PERR, 8'h00, 1'b0, 1'b0, 1'b0));
            m_ext = 1'b0; m_brk = 1'b0;
        end else if (bad_stop) begin
            exp_q.push_back(mk(K_FERR, 8'h00, 1'b0, 1'b0, 1'b0));
            m_ext = 1'b0; m_brk = 1'b0;
        end else begin
            exp_q.push_back(mk(K_SCAN, code, 1'b0, 1'b0, 1'b0));
            if (code == 8'hE0) m_ext = 1'b1;
            else if (code == 8'hF0) m_brk = 1'b1;
            else begin
                exp_q.push_back(mk(K_KEY, code, m_ext, m_brk, 1'b0));
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end
    endtask

    // Drive the first nbits of a frame; optional glitch in one bit's high
    // phase, optional reset pulse that abandons the frame.
    task automatic drive_bits(input logic [10:0] bits, input int nbits,
                              input int glitch_bit, input int rst_bit);
        for (int i = 0; i < nbits; i++) begin
            int h;
            h = $urandom_range(30, 45);
            kdata_i = bits[i];
            if (i == rst_bit) begin
                wait_cyc(h / 2);
                rst_i = 1'b1;
                wait_cyc(1);
                rst_i = 1'b0;
                m_ext = 1'b0; m_brk = 1'b0;
                kdata_i = 1'b1;
                wait_cyc(2);
                chk("busy_after_rst", busy_o, 0);
                wait_cyc(TO + 20);
                return;
            end
            if (i == glitch_bit) begin
                wait_cyc(15);
                kclk_i = 1'b0;
                wait_cyc(3);
                kclk_i = 1'b1;
                wait_cyc(h - 18);
            end else begin
                wait_cyc(h);
            end
            kclk_i = 1'b0;
            last_fall_drv = cyc;
            wait_cyc(h);
            kclk_i = 1'b1;
        end
        kdata_i = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                              input int glitch_bit, input int rst_bit);
        logic [10:0] bits;
        logic p;
        p = ~(^code);
        if (bad_par) p = ~p;
        bits = {~bad_stop, p, code, 1'b0};
        if (rst_bit < 0) expect_frame(code, bad_par, bad_stop);
        drive_bits(bits, 11, glitch_bit, rst_bit);
        wait_cyc(20);
    endtask

    // Monitor: pulses are consumed from the expectation queue in order and
    // must appear at the predicted cycle; held outputs follow the model.
    initial begin
        logic rst_s;
        ev_t  ev;
        forever begin
            @(posedge clk);
            rst_s = rst_i;
            @(negedge clk);
            if (rst_s) begin
                m_scan = 8'h00; m_key = 8'h00; m_kext = 1'b0; m_krel = 1'b0;
            end
            if (scan_valid_o) begin
                n_scan++;
                if (exp_q.size() > 0 && exp_q[0].kind == K_SCAN) begin
                    ev = exp_q.pop_front();
                    chk("scan_code", scan_code_o, ev.code);
                    chk("scan_latency", cyc, last_fall_drv + FL + 3);
                    m_scan = ev.code;
                    last_scan_cyc = cyc;
                end else chk("unexpected_scan_valid", scan_valid_o, 0);
            end
            if (parity_err_o) begin
                n_perr++;
                if (exp_q.size() > 0 && exp_q[0].kind == K_PERR) begin
                    ev = exp_q.pop_front();
                    chk("perr_latency", cyc, last_fall_drv + FL + 3);
                end else chk("unexpected_parity_err", parity_err_o, 0);
            end
            if (frame_err_o) begin
                n_ferr++;
                if (exp_q.size() > 0 && exp_q[0].kind == K_FERR) begin
                    ev = exp_q.pop_front();
                    if (ev.tmo) chk("timeout_latency", cyc, last_fall_drv + FL + 2 + TO);
                    else        chk("ferr_latency", cyc, last_fall_drv + FL + 3);
                end else chk("unexpected_frame_err", frame_err_o, 0);
            end
            if (key_valid_o) begin
                n_key++;
                if (exp_q.size() > 0 && exp_q[0].kind == K_KEY) begin
                    ev = exp_q.pop_front();
                    chk("key_latency", cyc, last_scan_cyc + 1);
                    m_key = ev.code; m_kext = ev.ext; m_krel = ev.rel;
                end else chk("unexpected_key_valid", key_valid_o, 0);
            end
            chk("scan_code_hold", scan_code_o, m_scan);
            chk("key_code_hold", key_code_o, m_key);
            chk("key_ext_hold", key_ext_o, m_kext);
            chk("key_release_hold", key_release_o, m_krel);
        end
    end

    initial begin
        int s0, k0, p0, f0;
        wait_cyc(5);
        chk("reset_busy", busy_o, 0);
        chk("reset_scan_code", scan_code_o, 0);
        rst_i = 1'b0;
        wait_cyc(20);

        // 1: single make code
        send_frame(8'h1C, 0, 0, -1, -1);
        chk("t1_scan_code", scan_code_o, 8'h1C);
        chk("t1_key_code", key_code_o, 8'h1C);
        chk("t1_ext", key_ext_o, 0);
        chk("t1_rel", key_release_o, 0);

        // 2: extended break sequence then a plain make
        s0 = n_scan; k0 = n_key;
        send_frame(8'hE0, 0, 0, -1, -1);
        send_frame(8'hF0, 0, 0, -1, -1);
        send_frame(8'h1C, 0, 0, -1, -1);
        chk("t2_scan_pulses", n_scan - s0, 3);
        chk("t2_key_pulses", n_key - k0, 1);
        chk("t2_key_code", key_code_o, 8'h1C);
        chk("t2_ext", key_ext_o, 1);
        chk("t2_rel", key_release_o, 1);
        send_frame(8'h5C, 0, 0, -1, -1);
        chk("t2b_key_code", key_code_o, 8'h5C);
        chk("t2b_ext", key_ext_o, 0);
        chk("t2b_rel", key_release_o, 0);

        // 3: parity error keeps the old code and drops a pending prefix
        p0 = n_perr; s0 = n_scan;
        send_frame(8'h5C, 1, 0, -1, -1);
        chk("t3_perr_pulses", n_perr - p0, 1);
        chk("t3_no_scan", n_scan - s0, 0);
        chk("t3_scan_code_kept", scan_code_o, 8'h5C);
        send_frame(8'hE0, 0, 0, -1, -1);
        send_frame(8'h33, 1, 0, -1, -1);
        send_frame(8'h1C, 0, 0, -1, -1);
        chk("t3_key_code", key_code_o, 8'h1C);
        chk("t3_ext_cleared", key_ext_o, 0);

        // 4: stop bit low
        f0 = n_ferr; s0 = n_scan;
        send_frame(8'h1C, 0, 1, -1, -1);
        chk("t4_ferr_pulses", n_ferr - f0, 1);
        chk("t4_no_scan", n_scan - s0, 0);
        chk("t4_busy", busy_o, 0);

        // 5: truncated frame times out
        f0 = n_ferr;
        exp_q.push_back(mk(K_FERR, 8'h00, 1'b0, 1'b0, 1'b1));
        m_ext = 1'b0; m_brk = 1'b0;
        drive_bits(11'b000_1010_0101_0, 5, -1, -1);
        wait_cyc(12);
        chk("t5_busy_mid", busy_o, 1);
        wait_cyc(TO + 20);
        chk("t5_ferr_pulses", n_ferr - f0, 1);
        chk("t5_busy_after", busy_o, 0);
        send_frame(8'hA5, 0, 0, -1, -1);
        chk("t5_scan_code", scan_code_o, 8'hA5);

        // 6: glitches in idle and mid-frame, then reset mid-frame
        kclk_i = 1'b0; wait_cyc(3); kclk_i = 1'b1;
        wait_cyc(20);
        chk("t6_idle_glitch_busy", busy_o, 0);
        send_frame(8'h1C, 0, 0, 4, -1);
        chk("t6_glitch_scan_code", scan_code_o, 8'h1C);
        send_frame(8'h2D, 0, 0, -1, 5);
        chk("t6_rst_scan_code", scan_code_o, 0);
        chk("t6_rst_key_code", key_code_o, 0);
        send_frame(8'h2D, 0, 0, -1, -1);
        chk("t6_after_rst_scan", scan_code_o, 8'h2D);

        // Randomised traffic with prefixes and occasional corruption
        for (int n = 0; n < 25; n++) begin
            int r;
            logic [7:0] code;
            r = $urandom_range(0, 9);
            code = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            send_frame(code, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), -1, -1);
        end

        wait_cyc(20);
        chk("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
